// File: rtl/counter_91_pkg.sv
// Shared types and constants for the 91-cycle counter request sequencer.
package counter_91_pkg;

    localparam int unsigned DELAY_91   = 91;
    localparam int unsigned CYC_W      = 7;
    localparam int unsigned PEND_W_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef logic [CYC_W-1:0] cyc_t;

    // Saturating increment of the cycle counter.
    function automatic cyc_t cyc_inc(input cyc_t c);
        return (c == '1) ? c : c + CYC_W'(1);
    endfunction

endpackage

// File: rtl/counter_91_seq_if.sv
// Request handshake plus counter ld/dn link and status of the sequencer.
interface counter_91_seq_if #(
    parameter int unsigned PEND_W = 4
);

    logic              req_valid;
    logic              req_ready;
    logic              abort;
    logic              clr_err;
    logic              ld;
    logic              dn;
    logic              fire;
    logic              busy;
    logic [PEND_W-1:0] pend;
    logic              err;

    // master: request source and counter stage; slave: the sequencer
    modport master (
        output req_valid, abort, clr_err, dn,
        input  req_ready, ld, fire, busy, pend, err
    );

    modport slave (
        input  req_valid, abort, clr_err, dn,
        output req_ready, ld, fire, busy, pend, err
    );

endinterface

// File: rtl/ld_cycle_check.sv
// Tracks cycles since the last ld, detects completion and early/late dn, holds sticky err.
module ld_cycle_check
    import counter_91_pkg::*;
#(
    parameter int unsigned DELAY = DELAY_91
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic wait_i,
    input  logic dn_i,
    input  logic clr_err_i,
    output logic complete_c_o,
    output logic err_o
);

    localparam cyc_t TERM = CYC_W'(DELAY + 1);

    cyc_t cyc_q, cyc_d;
    logic err_q, err_d;
    logic early_c, late_c;

    // cyc == 0 is the ld cycle itself, where dn still shows the previous completion.
    always_comb begin
        early_c      = wait_i & dn_i & (cyc_q != '0) & (cyc_q < TERM);
        complete_c_o = wait_i & (cyc_q == TERM);
        late_c       = complete_c_o & ~dn_i;

        cyc_d = cyc_q;
        if (load_i) begin
            cyc_d = '0;
        end else if (wait_i) begin
            cyc_d = cyc_inc(cyc_q);
        end

        err_d = err_q;
        if (early_c | late_c) begin
            err_d = 1'b1;
        end else if (clr_err_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            err_q <= 1'b0;
        end else begin
            cyc_q <= cyc_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/counter_91_seq.sv
// Queues timer requests, issues one ld per request to the counter and pulses fire on each completion.
module counter_91_seq
    import counter_91_pkg::*;
#(
    parameter int unsigned DELAY  = DELAY_91,
    parameter int unsigned PEND_W = PEND_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    counter_91_seq_if.slave bus
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e            state_q;
    logic              ld_q;
    logic              fire_q;
    logic              busy_q;
    logic [PEND_W-1:0] pend_q;

    logic req_ready_c;
    logic accept_c;
    logic complete_c;
    logic load_c;
    logic err_w;

    assign req_ready_c = ~bus.abort & (pend_q != PEND_MAX);
    assign accept_c    = bus.req_valid & req_ready_c;

    // A new ld is issued from IDLE on accept, or on completion when more work is available.
    always_comb begin
        load_c = 1'b0;
        if (!bus.abort) begin
            if (state_q == IDLE) begin
                load_c = accept_c;
            end else begin
                load_c = complete_c & ((pend_q != '0) | accept_c);
            end
        end
    end

    ld_cycle_check #(
        .DELAY (DELAY)
    ) u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_c),
        .wait_i       (state_q == WAIT),
        .dn_i         (bus.dn),
        .clr_err_i    (bus.clr_err),
        .complete_c_o (complete_c),
        .err_o        (err_w)
    );

    // When the queue is empty an accept on completion goes straight in flight, so pend holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ld_q    <= 1'b0;
            fire_q  <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
        end else begin
            ld_q   <= load_c;
            fire_q <= 1'b0;
            if (bus.abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                pend_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept_c) begin
                            state_q <= WAIT;
                            busy_q  <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (complete_c) begin
                            fire_q <= 1'b1;
                            if (load_c) begin
                                pend_q <= pend_q - PEND_W'(pend_q != '0)
                                                 + PEND_W'(accept_c & (pend_q != '0));
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            pend_q <= pend_q + PEND_W'(accept_c);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.ld        = ld_q;
    assign bus.fire      = fire_q;
    assign bus.busy      = busy_q;
    assign bus.pend      = pend_q;
    assign bus.err       = err_w;

endmodule

// File: tb/tb_counter_91_seq.sv
// Bench for counter_91_seq: directed scenarios plus random traffic against a timestamp-based request model.
module tb_counter_91_seq;
    import counter_91_pkg::*;

    localparam int unsigned PEND_W = 4;
    localparam int DLY  = int'(DELAY_91);
    localparam int TERM = DLY + 1;
    localparam int CAP  = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    counter_91_seq_if #(.PEND_W(PEND_W)) bus ();

    counter_91_seq #(.DELAY(DELAY_91), .PEND_W(PEND_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int now      = 0;

    // request model: queued count, in-flight flag and the cycle its ld appeared
    int m_queued;
    bit m_busy;
    int m_ld_time;
    bit m_err;
    bit m_ld;
    bit m_fire;

    // counter-stage environment driving dn
    int c_last_ld;
    bit c_have_ld;
    bit dn_v;
    int fault_early;
    bit fault_late;
    int arm_early  = 0;
    bit arm_late   = 1'b0;
    bit rand_faults = 1'b0;

    int ld_log[$];
    int fire_log[$];
    int max_pend;
    int accepts;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, now);
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_reset();
        m_queued    = 0;
        m_busy      = 1'b0;
        m_ld_time   = 0;
        m_err       = 1'b0;
        m_ld        = 1'b0;
        m_fire      = 1'b0;
        c_have_ld   = 1'b0;
        c_last_ld   = 0;
        dn_v        = 1'b1;
        fault_early = 0;
        fault_late  = 1'b0;
        ld_log.delete();
        fire_log.delete();
        max_pend    = 0;
        accepts     = 0;
        now         = 0;
    endtask

    // Called at a falling edge: check this cycle, drive inputs, advance the model one cycle.
    task automatic step(input bit v, input bit ab, input bit clr);
        bit acc;
        bit early;
        bit late;
        bit nxt_ld;
        bit nxt_fire;
        bit rdy;
        int age;
        int r;

        check_eq("ld",   int'(bus.ld),   int'(m_ld));
        check_eq("fire", int'(bus.fire), int'(m_fire));
        check_eq("busy", int'(bus.busy), int'(m_busy));
        check_eq("pend", int'(bus.pend), m_queued);
        check_eq("err",  int'(bus.err),  int'(m_err));
        if (bus.ld === 1'b1)   ld_log.push_back(now);
        if (bus.fire === 1'b1) fire_log.push_back(now);
        if (int'(bus.pend) > max_pend) max_pend = int'(bus.pend);

        if (bus.ld === 1'b1) begin
            c_last_ld = now;
            c_have_ld = 1'b1;
            if (rand_faults) begin
                r           = int'($urandom_range(0, 9));
                fault_early = (r == 0) ? int'($urandom_range(1, DLY)) : 0;
                fault_late  = (r == 1);
            end else begin
                fault_early = arm_early;
                fault_late  = arm_late;
                arm_early   = 0;
                arm_late    = 1'b0;
            end
        end else if (c_have_ld) begin
            age  = now - c_last_ld;
            dn_v = (age >= TERM);
            if (age == fault_early) dn_v = 1'b1;
            if (fault_late && age == TERM) dn_v = 1'b0;
        end

        bus.req_valid = v;
        bus.abort     = ab;
        bus.clr_err   = clr;
        bus.dn        = dn_v;
        #1;
        rdy = !ab && (m_queued != CAP);
        check_eq("req_ready", int'(bus.req_ready), int'(rdy));
        acc = v && rdy;
        if (acc) accepts++;

        early    = 1'b0;
        late     = 1'b0;
        nxt_ld   = 1'b0;
        nxt_fire = 1'b0;
        if (m_busy) begin
            age   = now - m_ld_time;
            early = dn_v && age >= 1 && age <= DLY;
            late  = !dn_v && age == TERM;
        end

        if (ab) begin
            m_busy   = 1'b0;
            m_queued = 0;
        end else if (!m_busy) begin
            if (acc) begin
                m_busy    = 1'b1;
                m_ld_time = now + 1;
                nxt_ld    = 1'b1;
            end
        end else if (now - m_ld_time == TERM) begin
            nxt_fire = 1'b1;
            if (m_queued > 0 || acc) begin
                nxt_ld    = 1'b1;
                m_ld_time = now + 1;
                // the oldest queued request leaves; an arrival takes its place or goes straight in flight
                if (m_queued > 0) m_queued = m_queued - 1 + int'(acc);
            end else begin
                m_busy = 1'b0;
            end
        end else if (acc) begin
            m_queued++;
        end

        if (early || late) m_err = 1'b1;
        else if (clr)      m_err = 1'b0;
        m_ld   = nxt_ld;
        m_fire = nxt_fire;

        @(negedge clk);
        now++;
    endtask

    task automatic idle_until(input int t);
        while (now < t) step(1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset at a falling edge, checks reset values while low, releases at a falling edge.
    task automatic do_reset(input int cycles);
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.clr_err   = 1'b0;
        bus.dn        = 1'b1;
        repeat (cycles) begin
            #1;
            check_eq("rst_ld",        int'(bus.ld),        0);
            check_eq("rst_fire",      int'(bus.fire),      0);
            check_eq("rst_busy",      int'(bus.busy),      0);
            check_eq("rst_pend",      int'(bus.pend),      0);
            check_eq("rst_err",       int'(bus.err),       0);
            check_eq("rst_req_ready", int'(bus.req_ready), 1);
            @(negedge clk);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int  exp_ld[3];
        int  exp_fire[3];
        bit  full_seen;
        bit  v;
        bit  ab;
        bit  clr;

        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.clr_err   = 1'b0;
        bus.dn        = 1'b1;
        model_reset();
        @(negedge clk);

        // single request from IDLE
        do_reset(3);
        idle_until(10);
        step(1'b1, 1'b0, 1'b0);
        idle_until(110);
        check_eq("t1_ld_count",   ld_log.size(),     1);
        check_eq("t1_ld_at",      q_at(ld_log, 0),   11);
        check_eq("t1_fire_count", fire_log.size(),   1);
        check_eq("t1_fire_at",    q_at(fire_log, 0), 104);
        check_eq("t1_busy_end",   int'(bus.busy),    0);
        check_eq("t1_err_end",    int'(bus.err),     0);

        // three back-to-back requests
        do_reset(2);
        idle_until(10);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        idle_until(300);
        exp_ld   = '{11, 104, 197};
        exp_fire = '{104, 197, 290};
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_ld_at",   q_at(ld_log, i),   exp_ld[i]);
            check_eq("t2_fire_at", q_at(fire_log, i), exp_fire[i]);
        end
        check_eq("t2_pend_peak", max_pend,        2);
        check_eq("t2_pend_end",  int'(bus.pend),  0);

        // fill the queue, keep offering until one more is taken on a dequeue
        do_reset(2);
        idle_until(10);
        full_seen = 1'b0;
        for (int i = 0; i < 3000 && accepts < 17; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (int'(bus.pend) == CAP && bus.req_ready === 1'b0) full_seen = 1'b1;
        end
        check_eq("t3_full_blocks", int'(full_seen), 1);
        check_eq("t3_accepts",     accepts,         17);
        for (int i = 0; i < 1700; i++) step(1'b0, 1'b0, 1'b0);
        check_eq("t3_fires",    fire_log.size(), 17);
        check_eq("t3_pend_end", int'(bus.pend),  0);

        // abort with requests pending, then restart
        do_reset(2);
        idle_until(10);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        idle_until(50);
        step(1'b0, 1'b1, 1'b0);
        check_eq("t4_busy51", int'(bus.busy), 0);
        check_eq("t4_pend51", int'(bus.pend), 0);
        idle_until(60);
        step(1'b1, 1'b0, 1'b0);
        idle_until(170);
        check_eq("t4_fire_count", fire_log.size(),                   1);
        check_eq("t4_fire_at",    q_at(fire_log, 0),                 154);
        check_eq("t4_last_ld",    q_at(ld_log, ld_log.size() - 1),   61);

        // early dn, clear, then late dn
        do_reset(2);
        arm_early = 40;
        idle_until(10);
        step(1'b1, 1'b0, 1'b0);
        idle_until(52);
        check_eq("t5_err_early", int'(bus.err),   1);
        check_eq("t5_no_fire",   fire_log.size(), 0);
        idle_until(110);
        check_eq("t5_fire_after_early", fire_log.size(), 1);
        step(1'b0, 1'b0, 1'b1);
        check_eq("t5_err_cleared", int'(bus.err), 0);
        arm_late = 1'b1;
        idle_until(120);
        step(1'b1, 1'b0, 1'b0);
        idle_until(220);
        check_eq("t5_err_late",  int'(bus.err),                       1);
        check_eq("t5_late_fire", q_at(fire_log, fire_log.size() - 1), 214);

        // reset in the middle of a wait, stale dn afterwards
        do_reset(2);
        idle_until(10);
        step(1'b1, 1'b0, 1'b0);
        idle_until(50);
        do_reset(3);
        idle_until(150);
        check_eq("t6_no_fire", fire_log.size(), 0);
        check_eq("t6_no_ld",   ld_log.size(),   0);

        // random traffic with injected timing faults
        do_reset(2);
        rand_faults = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            v   = ($urandom_range(0, 7) == 0);
            ab  = ($urandom_range(0, 399) == 0);
            clr = ($urandom_range(0, 63) == 0);
            step(v, ab, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
